// File: rtl/hash_pkg.sv
// Shared definitions for the SHA-2 chaining-value accumulator: FSM states,
// standard initial hash values and the beat-count helper.
package hash_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_HOLD = 2'd2
    } acc_state_e;

    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [511:0] SHA512_IV = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
        64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
        64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    function automatic int calc_beats(input int num_words, input int lanes);
        return num_words / lanes;
    endfunction

endpackage

// File: rtl/hash_state_acc_if.sv
// Handshake and data bundle between the compression core / digest consumer
// and the chaining-value accumulator.
interface hash_state_acc_if #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 8
);
    logic                          init;
    logic                          in_valid;
    logic                          in_ready;
    logic [NUM_WORDS*WORD_W-1:0]   in_data;
    logic                          in_last;
    logic [NUM_WORDS*WORD_W-1:0]   state_out;
    logic                          digest_valid;
    logic                          digest_ready;

    modport master (
        output init, in_valid, in_data, in_last, digest_ready,
        input  in_ready, state_out, digest_valid
    );

    modport slave (
        input  init, in_valid, in_data, in_last, digest_ready,
        output in_ready, state_out, digest_valid
    );
endinterface

// File: rtl/hash_state_acc.sv
// Chaining-value register: loads the IV and adds each compression result into
// the state, LANES words per beat, then holds the final digest for the consumer.
module hash_state_acc
    import hash_pkg::*;
#(
    parameter int                          WORD_W    = 32,
    parameter int                          NUM_WORDS = 8,
    parameter int                          LANES     = 8,
    parameter logic [NUM_WORDS*WORD_W-1:0] IV        = SHA256_IV
) (
    input  logic              clk,
    input  logic              rst_n,
    hash_state_acc_if.slave   bus
);

    localparam int BEATS  = calc_beats(NUM_WORDS, LANES);
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int DATA_W = NUM_WORDS * WORD_W;

    if (NUM_WORDS % LANES != 0) begin : g_bad_lanes
        $error("hash_state_acc: NUM_WORDS must be divisible by LANES");
    end

    acc_state_e               fsm_q, fsm_d;
    logic [DATA_W-1:0]        state_q, state_d;
    logic [DATA_W-1:0]        buf_q, buf_d;
    logic                     last_q, last_d;
    logic [BEAT_W-1:0]        beat_q, beat_d;
    logic                     in_ready_s;
    logic                     digest_valid_s;
    logic [WORD_W-1:0]        lane_sum_s [LANES];

    // Lane l works on word beat*LANES+l; word 0 sits at the MSBs, carry dropped.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        int idx_s;
        assign idx_s = int'(beat_q) * LANES + l;
        assign lane_sum_s[l] = state_q[(NUM_WORDS-1-idx_s)*WORD_W +: WORD_W]
                             + buf_q[(NUM_WORDS-1-idx_s)*WORD_W +: WORD_W];
    end

    // Next-state and handshake outputs.
    always_comb begin
        fsm_d          = fsm_q;
        state_d        = state_q;
        buf_d          = buf_q;
        last_d         = last_q;
        beat_d         = beat_q;
        in_ready_s     = 1'b0;
        digest_valid_s = 1'b0;
        case (fsm_q)
            ST_IDLE: begin
                in_ready_s = ~bus.init;
                if (bus.init) begin
                    state_d = IV;
                end else if (bus.in_valid) begin
                    buf_d  = bus.in_data;
                    last_d = bus.in_last;
                    beat_d = '0;
                    fsm_d  = ST_ACC;
                end else begin
                    fsm_d = ST_IDLE;
                end
            end
            ST_ACC: begin
                for (int l = 0; l < LANES; l++) begin
                    state_d[(NUM_WORDS-1-(int'(beat_q)*LANES+l))*WORD_W +: WORD_W] = lane_sum_s[l];
                end
                if (beat_q == BEAT_W'(BEATS-1)) begin
                    beat_d = '0;
                    fsm_d  = last_q ? ST_HOLD : ST_IDLE;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                end
            end
            ST_HOLD: begin
                digest_valid_s = 1'b1;
                if (bus.digest_ready) begin
                    state_d = IV;
                    fsm_d   = ST_IDLE;
                end else begin
                    fsm_d = ST_HOLD;
                end
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset discards any partial sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= ST_IDLE;
            state_q <= IV;
            buf_q   <= '0;
            last_q  <= 1'b0;
            beat_q  <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            buf_q   <= buf_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

    assign bus.in_ready     = in_ready_s;
    assign bus.digest_valid = digest_valid_s;
    assign bus.state_out    = state_q;

endmodule

// File: tb/tb_hash_state_acc.sv
// Directed bench: a fully parallel instance (LANES=8) and a serialised
// instance (LANES=2) driven with hand-computed SHA-256 vectors.
module tb_hash_state_acc;
    import hash_pkg::*;

    localparam logic [255:0] IV_C     = SHA256_IV;
    localparam logic [255:0] ABC_DATA = {
        32'h506e3058, 32'hd39a2165, 32'h04d24d6c, 32'hb85e2ce9,
        32'h5ef50f24, 32'hfb121210, 32'h948d25b6, 32'h961f4894
    };
    localparam logic [255:0] ABC_DIG = {
        32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
        32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
    };
    localparam logic [255:0] WRAP1_DATA = {32'h95f61998, 224'd0};
    localparam logic [255:0] WRAP2_DATA = {32'h00000002, 224'd0};
    localparam logic [255:0] WRAP1_EXP  = {32'hffffffff, IV_C[223:0]};
    localparam logic [255:0] WRAP2_EXP  = {32'h00000001, IV_C[223:0]};

    logic clk;
    logic rst8_n;
    logic rst2_n;
    int   checks;
    int   failures;

    hash_state_acc_if #(.WORD_W(32), .NUM_WORDS(8)) b8 ();
    hash_state_acc_if #(.WORD_W(32), .NUM_WORDS(8)) b2 ();

    hash_state_acc #(.WORD_W(32), .NUM_WORDS(8), .LANES(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst8_n),
        .bus   (b8)
    );

    hash_state_acc #(.WORD_W(32), .NUM_WORDS(8), .LANES(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst2_n),
        .bus   (b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst8_n = 1'b0;
        rst2_n = 1'b0;
        b8.init = 1'b0; b8.in_valid = 1'b0; b8.in_data = '0; b8.in_last = 1'b0; b8.digest_ready = 1'b0;
        b2.init = 1'b0; b2.in_valid = 1'b0; b2.in_data = '0; b2.in_last = 1'b0; b2.digest_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst8_n = 1'b1;
        rst2_n = 1'b1;
        @(negedge clk);

        chk("rst8_state", b8.state_out, IV_C);
        chk("rst8_ready", 256'(b8.in_ready), 256'd1);
        chk("rst8_dv",    256'(b8.digest_valid), 256'd0);
        chk("rst2_state", b2.state_out, IV_C);

        // "abc" single block, fully parallel
        b8.in_data = ABC_DATA; b8.in_last = 1'b1; b8.in_valid = 1'b1;
        @(negedge clk);
        b8.in_valid = 1'b0; b8.in_data = '0;
        chk("abc8_acc_ready", 256'(b8.in_ready), 256'd0);
        chk("abc8_acc_dv",    256'(b8.digest_valid), 256'd0);
        @(negedge clk);
        chk("abc8_dv",     256'(b8.digest_valid), 256'd1);
        chk("abc8_digest", b8.state_out, ABC_DIG);

        // Backpressure in HOLD with init and in_valid pushed at it
        b8.in_valid = 1'b1; b8.init = 1'b1; b8.in_data = WRAP1_DATA; b8.in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_dv",    256'(b8.digest_valid), 256'd1);
            chk("hold_state", b8.state_out, ABC_DIG);
            chk("hold_ready", 256'(b8.in_ready), 256'd0);
        end
        b8.in_valid = 1'b0; b8.init = 1'b0; b8.digest_ready = 1'b1;
        @(negedge clk);
        b8.digest_ready = 1'b0;
        chk("release_state", b8.state_out, IV_C);
        chk("release_dv",    256'(b8.digest_valid), 256'd0);
        chk("release_ready", 256'(b8.in_ready), 256'd1);

        // Wrap-around on word 0 over two non-last blocks
        b8.in_data = WRAP1_DATA; b8.in_last = 1'b0; b8.in_valid = 1'b1;
        @(negedge clk);
        b8.in_valid = 1'b0;
        @(negedge clk);
        chk("wrap1_state", b8.state_out, WRAP1_EXP);
        chk("wrap1_ready", 256'(b8.in_ready), 256'd1);
        b8.in_data = WRAP2_DATA; b8.in_valid = 1'b1;
        @(negedge clk);
        b8.in_valid = 1'b0;
        @(negedge clk);
        chk("wrap2_state", b8.state_out, WRAP2_EXP);
        chk("wrap2_ready", 256'(b8.in_ready), 256'd1);
        chk("wrap2_dv",    256'(b8.digest_valid), 256'd0);

        // init in IDLE reloads IV and blocks the simultaneous in_valid
        b8.init = 1'b1; b8.in_valid = 1'b1; b8.in_data = ABC_DATA; b8.in_last = 1'b1;
        #1;
        chk("init_ready_low", 256'(b8.in_ready), 256'd0);
        @(negedge clk);
        b8.init = 1'b0; b8.in_valid = 1'b0;
        chk("init_state", b8.state_out, IV_C);
        @(negedge clk);
        chk("init_idle_ready", 256'(b8.in_ready), 256'd1);
        chk("init_idle_state", b8.state_out, IV_C);

        // Serialised "abc": four ACC cycles then digest
        b2.in_data = ABC_DATA; b2.in_last = 1'b1; b2.in_valid = 1'b1;
        @(negedge clk);
        b2.in_valid = 1'b0; b2.in_data = '0;
        for (int i = 0; i < 4; i++) begin
            chk("abc2_acc_ready", 256'(b2.in_ready), 256'd0);
            chk("abc2_acc_dv",    256'(b2.digest_valid), 256'd0);
            @(negedge clk);
        end
        chk("abc2_dv",     256'(b2.digest_valid), 256'd1);
        chk("abc2_digest", b2.state_out, ABC_DIG);
        b2.digest_ready = 1'b1;
        @(negedge clk);
        b2.digest_ready = 1'b0;
        chk("abc2_release", b2.state_out, IV_C);

        // Reset during beat 1 of a serialised accumulation
        b2.in_data = ABC_DATA; b2.in_last = 1'b1; b2.in_valid = 1'b1;
        @(negedge clk);
        b2.in_valid = 1'b0;
        @(negedge clk);
        rst2_n = 1'b0;
        #1;
        chk("midrst_state", b2.state_out, IV_C);
        chk("midrst_ready", 256'(b2.in_ready), 256'd1);
        @(negedge clk);
        rst2_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("postrst_dv",    256'(b2.digest_valid), 256'd0);
        chk("postrst_state", b2.state_out, IV_C);
        chk("postrst_ready", 256'(b2.in_ready), 256'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hash_state_acc.md
# hash_state_acc

Parametrised chaining-value register for the SHA-2 datapath: holds the hash state, loads the initial value (IV), and adds each compression-round result into the state word-wise modulo 2^WORD_W. It sits between the compression core and the digest output. It adds reset, IV load, a valid/ready handshake, a configurable adder width that trades area for latency, and a held digest output.

## Interface
- WORD_W, default 32: word width in bits; 64 for SHA-512.
- NUM_WORDS, default 8: words of hash state.
- LANES, default 8: word adders per cycle.
  - NUM_WORDS must be divisible by LANES.
  - BEATS = NUM_WORDS/LANES.
- IV, default SHA-256 IV from the package, NUM_WORDS*WORD_W bits: initial and post-digest state.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- init  in  1  load IV into the state; honoured only in IDLE.
- in_valid  in  1  compression result is valid.
- in_ready  out  1  block can accept a compression result.
- in_data  in  NUM_WORDS*WORD_W  compression result; word 0 at the MSBs.
- in_last  in  1  this block is the final block of the message.
- state_out  out  NUM_WORDS*WORD_W  current chaining value, fed to the compression core.
- digest_valid  out  1  final digest is held on state_out.
- digest_ready  in  1  consumer accepts the digest.

## Operation
- FSM states: IDLE, ACC, HOLD.
- Reset values:
  - FSM = IDLE, state = IV, beat counter = 0.
  - in_ready = 1, digest_valid = 0.
- IDLE:
  - in_ready = !init.
  - If init = 1, state <= IV and any in_valid is ignored.
  - Otherwise, when in_valid && in_ready: capture in_data into the operand buffer, latch in_last, clear the beat counter, and go to ACC.
- ACC:
  - in_ready = 0.
  - On beat k, words k*LANES through k*LANES+LANES-1 update as state[i] <= state[i] + buf[i], truncated to WORD_W bits. The carry-out is discarded.
  - On the final beat (k = BEATS-1), go to HOLD if in_last was latched, else go to IDLE.
  - init is ignored.
- HOLD:
  - digest_valid = 1 and in_ready = 0.
  - state_out is stable.
  - When digest_ready = 1: state <= IV, go to IDLE. digest_valid falls on the next cycle.
  - init is ignored.
- state_out always reflects the registered state. Mid-ACC, state_out is partially updated and must not be used until in_ready returns to 1.
- If rst_n is asserted mid-ACC or mid-HOLD, the block returns immediately to reset values and discards the partial sum.

## Timing
- Accept to update complete: BEATS cycles. in_ready rises (non-last block) or digest_valid rises (last block) at accept edge + BEATS.
- With LANES = NUM_WORDS, back-to-back blocks are accepted every 2 cycles: accept, then one ACC cycle.
- Throughput limit: one block per BEATS+1 cycles.
- A digest handshake on cycle n allows a new accept on cycle n+1.
- in_valid held with in_ready = 0 has no effect. in_data need not be held after acceptance.

## Structure
- Shared package hash_pkg holds:
  - the FSM state enum;
  - SHA-256 and SHA-512 IV constants;
  - a function computing BEATS.
- An elaboration-time check that NUM_WORDS % LANES == 0 belongs in the module.
- No sub-module: the lane adders are a generate loop indexed by the beat counter.

## Test plan
- Reset then idle: after rst_n rises, state_out equals the SHA-256 IV (6a09e667 bb67ae85 … 5be0cd19), in_ready = 1, digest_valid = 0.
- SHA-256 "abc", LANES=8:
  - Stimulus: in_data = 506e3058 d39a2165 04d24d6c b85e2ce9 5ef50f24 fb121210 948d25b6 961f4894, in_last = 1.
  - Response: 1 cycle later digest_valid = 1 and state_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Serialised mode, LANES=2: same stimulus gives the same digest 4 cycles after accept; in_ready stays 0 for those 4 cycles.
- Wrap-around:
  - Stimulus: state word 0 = ffffffff, in_data word 0 = 00000002, in_last = 0.
  - Response: state word 0 = 00000001, no digest_valid, in_ready = 1 next cycle.
- Backpressure and re-init:
  - Hold digest_ready = 0 for 5 cycles: digest_valid and state_out are stable, and in_valid is not accepted.
  - Then assert digest_ready: state_out = IV the next cycle.
  - init asserted in HOLD has no effect.
- Reset mid-ACC (LANES=2, beat 1): rst_n pulse returns state_out to IV and FSM to IDLE.
